button_event_gen: RTL
=====================

Name: button_event_gen

Overview:
- Front end for the clock-control FSM.
- Converts three raw, bouncing board inputs (increment button, set button, mode slide switch) into the clean control signals the FSM consumes:
  - single-cycle `inc_short`, `inc_long` and `set` pulses;
  - debounced `sw` level.
- Sits between the board I/O and the FSM, in the same clock domain.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a new button level (10 ms at 50 MHz).
- LONG_CYCLES, 50000000, debounced hold duration that classifies an increment press as long (1 s).
- REPEAT_CYCLES, 12500000, interval between repeated inc_long pulses while held; used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- btn_inc  in  1  raw increment button, asynchronous, active-high
- btn_set  in  1  raw set button, asynchronous, active-high
- btn_sw  in  1  raw mode slide switch, asynchronous
- inc_short  out  1  one-cycle pulse: increment press released before LONG_CYCLES
- inc_long  out  1  one-cycle pulse: increment press reached LONG_CYCLES
- set  out  1  one-cycle pulse on debounced set press
- sw  out  1  debounced switch level

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `rst`. While `rst` is high at a clk edge:
  - all synchronizers, debounced levels, counters and the FSM clear to 0/IDLE;
  - all outputs are 0 the following cycle.
- Synchronization and debounce, per input:
  - Each input passes a 2-flop synchronizer, then a debouncer.
  - The debouncer holds a stable level. A counter increments each cycle the synchronized sample differs from the stable level. The counter clears whenever the sample equals the stable level.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- Latency:
  - Raw edge to debounced edge: 2 + DEBOUNCE_CYCLES cycles.
  - Every pulse output is registered, adding +1 cycle.
- sw: equals the debounced btn_sw level, with no pulse generation.
- set: asserted for exactly 1 cycle after each debounced rising edge of btn_set. Release produces nothing.
- Increment FSM, driven by the debounced inc level (d):
  - IDLE: when d rises, go to PRESSED and set hold_cnt = 1.
  - PRESSED:
    - If d is high, hold_cnt increments.
    - When hold_cnt reaches LONG_CYCLES, pulse inc_long and go to LONG_HELD.
    - If d falls first, pulse inc_short and go to IDLE.
  - LONG_HELD: wait for d low, then go to IDLE. No inc_short on release.
- A debounced high duration of exactly LONG_CYCLES yields inc_long only.
- Counters saturate and never wrap.
- inc_short and inc_long are never high in the same cycle.
- The inc and set paths are fully independent. Simultaneous presses each produce their own pulses in the same cycle if aligned.
- Reset mid-press: FSM returns to IDLE and no pulse is emitted for the interrupted press. A button still held after reset is re-debounced from 0 and is treated as a new press.
- Counter widths: $clog2(param + 1) bits.

Optional Feature:
- AUTO_REPEAT_EN defined:
  - In LONG_HELD, a repeat counter reloads on entry.
  - inc_long pulses again every REPEAT_CYCLES cycles while d stays high.
  - Release stops repeats immediately; no pulse is emitted in the release cycle.
- AUTO_REPEAT_EN undefined: exactly one inc_long per press, and REPEAT_CYCLES is unused.

Decomposition:
- Shared package `clock_ctrl_pkg`:
  - increment FSM state enum (IDLE, PRESSED, LONG_HELD);
  - default timing constants (CLK_HZ = 50_000_000, and debounce/long/repeat counts derived from it).
- One sub-module, `button_debounce` (synchronizer + debouncer, parameter DEBOUNCE_CYCLES, ports clk, rst, raw, level):
  - instantiated three times;
  - edge detection and classification stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8):
- btn_inc high 3 cycles, then low -> no inc_short/inc_long pulse; debounced level never rises.
- btn_inc high 10 cycles -> exactly one inc_short, 1 cycle after the debounced fall (raw fall + 7); zero inc_long.
- btn_inc high so the debounced level stays high 40 cycles -> inc_long 20 cycles after the debounced rise, and no inc_short.
  - Without macro: 1 inc_long.
  - With AUTO_REPEAT_EN: 3 pulses, at offsets 20, 28, 36.
- btn_set high 10 cycles, concurrently with a 10-cycle btn_inc press -> one set pulse at raw rise + 7, one inc_short; release of set gives no pulse.
- btn_sw toggled 0->1 with a 2-cycle bounce, then held -> sw rises exactly 6 cycles after the final stable edge, and never pulses during the bounce.
- rst asserted for 1 cycle after btn_inc has been debounced-high 15 cycles -> all outputs 0, no pulse for that press. Button still held: new press recognized after 4 more stable cycles, inc_long after a further 20.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and default timing for the clock-control front end and FSM.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } inc_state_t;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;        // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 4;    // 250 ms

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw board input.
module button_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // The flip happens on the cycle the count would reach DEBOUNCE_CYCLES,
    // so a new level needs exactly DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/button_event_gen.sv
// Board buttons/switch to clean FSM controls: inc_short/inc_long/set pulses and sw level.
// Define AUTO_REPEAT_EN to repeat inc_long every REPEAT_CYCLES while the press is held.
module button_event_gen
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc,
    input  logic btn_set,
    input  logic btn_sw,
    output logic inc_short,
    output logic inc_long,
    output logic set,
    output logic sw
);

    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic w_inc_lvl;
    logic w_set_lvl;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_inc),
        .level (w_inc_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_set),
        .level (w_set_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_sw),
        .level (sw)
    );

    logic r_set_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_set_prev <= 1'b0;
            set        <= 1'b0;
        end else begin
            r_set_prev <= w_set_lvl;
            set        <= w_set_lvl & ~r_set_prev;
        end
    end

    inc_state_t    r_state;
    logic [HW-1:0] r_hold;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] r_rpt;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = |REPEAT_CYCLES;
`endif

    // r_hold counts debounced-high samples; the long decision fires on the
    // sample that would make it LONG_CYCLES, so it never exceeds HOLD_LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            inc_short <= 1'b0;
            inc_long  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_rpt     <= '0;
`endif
        end else begin
            inc_short <= 1'b0;
            inc_long  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_inc_lvl) begin
                        r_state <= PRESSED;
                        r_hold  <= HW'(1);
                    end
                end
                PRESSED: begin
                    if (!w_inc_lvl) begin
                        inc_short <= 1'b1;
                        r_state   <= IDLE;
                        r_hold    <= '0;
                    end else if (r_hold >= HOLD_LAST) begin
                        inc_long <= 1'b1;
                        r_state  <= LONG_HELD;
                        r_hold   <= '0;
`ifdef AUTO_REPEAT_EN
                        r_rpt    <= '0;
`endif
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                LONG_HELD: begin
                    if (!w_inc_lvl) begin
                        r_state <= IDLE;
`ifdef AUTO_REPEAT_EN
                    end else if (r_rpt >= RPT_LAST) begin
                        inc_long <= 1'b1;
                        r_rpt    <= '0;
                    end else begin
                        r_rpt <= r_rpt + RW'(1);
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
